// File: rtl/or_tree_pkg.sv
// Shared encodings and helpers for the pipelined N-input reduction tree.
package or_tree_pkg;

    typedef enum logic [1:0] {
        OP_OR  = 2'b00,
        OP_AND = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    // Pipeline depth: ceil(log2(w)), never less than one stage.
    function automatic int unsigned clog2_min1(input int unsigned w);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < w) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

    // Padding value that leaves the reduction result unchanged.
    function automatic logic op_identity(input op_e op);
        return (op == OP_AND);
    endfunction

    // Pairwise tree operator; NOR reduces as OR and inverts at the root.
    function automatic logic combine_pair(input op_e op, input logic hi, input logic lo);
        logic r;
        case (op)
            OP_AND:  r = hi & lo;
            OP_XOR:  r = hi ^ lo;
            default: r = hi | lo;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/or_tree_pipe_if.sv
// Sample/result bus of or_tree_pipe; sticky signals exist only with OR_TREE_STICKY_EN.
interface or_tree_pipe_if
    import or_tree_pkg::*;
#(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    op_e              op;
    logic             out_valid;
    logic             out;
`ifdef OR_TREE_STICKY_EN
    logic             sticky;
    logic             sticky_clr;

    modport master (output in_valid, a, op, sticky_clr, input out_valid, out, sticky);
    modport slave  (input in_valid, a, op, sticky_clr, output out_valid, out, sticky);
`else
    modport master (output in_valid, a, op, input out_valid, out);
    modport slave  (input in_valid, a, op, output out_valid, out);
`endif
endinterface

// File: rtl/or_tree_stage.sv
// One tree level: pairwise combine of IN_W bits, registering data, op and valid.
module or_tree_stage
    import or_tree_pkg::*;
#(
    parameter int unsigned IN_W = 2,
    parameter bit          LAST = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [IN_W-1:0]      data_i,
    input  op_e                  op_i,
    input  logic                 valid_i,
    output logic [IN_W/2-1:0]    data_o,
    output op_e                  op_o,
    output logic                 valid_o
);
    localparam int unsigned OUT_W = IN_W / 2;

    logic [OUT_W-1:0] data_d, data_q;
    op_e              op_q;
    logic             valid_q;

    // The root stage folds the NOR inversion in so the result leaves a register.
    always_comb begin
        data_d = '0;
        for (int j = 0; j < int'(OUT_W); j++) begin
            data_d[j] = combine_pair(op_i, data_i[2*j+1], data_i[2*j]);
        end
        if (LAST && (op_i == OP_NOR)) data_d[0] = ~data_d[0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            op_q    <= OP_OR;
            valid_q <= 1'b0;
        end else if (en) begin
            data_q  <= data_d;
            op_q    <= op_i;
            valid_q <= valid_i;
        end
    end

    assign data_o  = data_q;
    assign op_o    = op_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/or_tree_pipe.sv
// Pipelined WIDTH-input OR/AND/XOR/NOR reduction, one register per tree level.
// Optional OR_TREE_STICKY_EN adds a sticky result-seen flag with clear input.
module or_tree_pipe
    import or_tree_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    or_tree_pipe_if.slave  bus
);
    localparam int unsigned LEVELS = clog2_min1(WIDTH);
    localparam int unsigned PAD_W  = 1 << LEVELS;
    localparam int unsigned NODE_W = 2 * PAD_W - 1;

    // All tree levels packed back to back: level k starts at 2*PAD_W - 2*(PAD_W>>k).
    logic [NODE_W-1:0] node;
    op_e               op_lvl [0:LEVELS];
    logic [LEVELS:0]   valid_lvl;

    for (genvar i = 0; i < int'(PAD_W); i++) begin : g_pad
        if (i < int'(WIDTH)) begin : g_bit
            assign node[i] = bus.a[i];
        end else begin : g_id
            assign node[i] = op_identity(bus.op);
        end
    end

    assign op_lvl[0]    = bus.op;
    assign valid_lvl[0] = bus.in_valid;

    for (genvar k = 1; k <= int'(LEVELS); k++) begin : g_lvl
        localparam int unsigned IN_W    = PAD_W >> (k - 1);
        localparam int unsigned IN_OFF  = 2 * PAD_W - 2 * IN_W;
        localparam int unsigned OUT_OFF = 2 * PAD_W - IN_W;

        or_tree_stage #(
            .IN_W (IN_W),
            .LAST (k == int'(LEVELS))
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .data_i  (node[IN_OFF +: IN_W]),
            .op_i    (op_lvl[k-1]),
            .valid_i (valid_lvl[k-1]),
            .data_o  (node[OUT_OFF +: IN_W/2]),
            .op_o    (op_lvl[k]),
            .valid_o (valid_lvl[k])
        );
    end

    assign bus.out       = node[NODE_W-1];
    assign bus.out_valid = valid_lvl[LEVELS];

`ifdef OR_TREE_STICKY_EN
    localparam int unsigned ROOT_IN_OFF = 2 * PAD_W - 4;

    logic out_next_c;
    logic sticky_d, sticky_q;

    // Mirror of the root stage's next value so sticky sets on the same edge as out.
    always_comb begin
        out_next_c = combine_pair(op_lvl[LEVELS-1], node[ROOT_IN_OFF+1], node[ROOT_IN_OFF]);
        if (op_lvl[LEVELS-1] == OP_NOR) out_next_c = ~out_next_c;
        sticky_d = (sticky_q & ~bus.sticky_clr) | (valid_lvl[LEVELS-1] & out_next_c);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)  sticky_q <= 1'b0;
        else if (en) sticky_q <= sticky_d;
    end

    assign bus.sticky = sticky_q;
`endif

endmodule

// File: tb/tb_or_tree_pipe.sv
// Directed self-checking bench for or_tree_pipe (WIDTH 8 and WIDTH 5 instances).
module tb_or_tree_pipe;
    import or_tree_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    or_tree_pipe_if #(.WIDTH(8)) bus8 ();
    or_tree_pipe_if #(.WIDTH(5)) bus5 ();

    or_tree_pipe #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .en(en), .bus(bus8));
    or_tree_pipe #(.WIDTH(5)) dut5 (.clk(clk), .rst_n(rst_n), .en(en), .bus(bus5));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic v, input logic [7:0] a, input op_e op);
        bus8.in_valid = v;
        bus8.a        = a;
        bus8.op       = op;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_cmp++; if (bus8.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid8: got %b want 0", bus8.out_valid); end
        n_cmp++; if (bus8.out !== 1'b0) begin n_bad++; $display("FAIL reset_out8: got %b want 0", bus8.out); end
        n_cmp++; if (bus5.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid5: got %b want 0", bus5.out_valid); end
`ifdef OR_TREE_STICKY_EN
        n_cmp++; if (bus8.sticky !== 1'b0) begin n_bad++; $display("FAIL reset_sticky: got %b want 0", bus8.sticky); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_sweep();
        logic [7:0] va [5] = '{8'h00, 8'h01, 8'h00, 8'h02, 8'hFF};
        logic       ex [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            if (i < 5) drive8(1'b1, va[i], OP_OR);
            else       drive8(1'b0, 8'h00, OP_OR);
            step();
            if (i >= 2 && i < 7) begin
                n_cmp++; if (bus8.out_valid !== 1'b1) begin n_bad++; $display("FAIL sweep_valid[%0d]: got %b want 1", i-2, bus8.out_valid); end
                n_cmp++; if (bus8.out !== ex[i-2]) begin n_bad++; $display("FAIL sweep_out[%0d]: got %b want %b", i-2, bus8.out, ex[i-2]); end
            end
            if (i == 7) begin
                n_cmp++; if (bus8.out_valid !== 1'b0) begin n_bad++; $display("FAIL sweep_bubble: got %b want 0", bus8.out_valid); end
            end
        end
    endtask

    task automatic test_mixed();
        logic [7:0] va [4] = '{8'hFF, 8'hFE, 8'h07, 8'h00};
        op_e        vo [4] = '{OP_AND, OP_AND, OP_XOR, OP_NOR};
        logic       ex [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive8(1'b1, va[i], vo[i]);
            else       drive8(1'b0, 8'h00, OP_OR);
            step();
            if (i >= 2) begin
                n_cmp++; if (bus8.out_valid !== 1'b1) begin n_bad++; $display("FAIL mixed_valid[%0d]: got %b want 1", i-2, bus8.out_valid); end
                n_cmp++; if (bus8.out !== ex[i-2]) begin n_bad++; $display("FAIL mixed_out[%0d]: got %b want %b", i-2, bus8.out, ex[i-2]); end
            end
        end
        step();
    endtask

    task automatic test_odd_width();
        logic [4:0] va [3] = '{5'h1F, 5'h10, 5'h0F};
        op_e        vo [3] = '{OP_AND, OP_OR, OP_AND};
        logic       ex [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            bus5.in_valid = (i < 3);
            bus5.a        = (i < 3) ? va[i] : 5'h00;
            bus5.op       = (i < 3) ? vo[i] : OP_OR;
            step();
            if (i >= 2) begin
                n_cmp++; if (bus5.out_valid !== 1'b1) begin n_bad++; $display("FAIL odd_valid[%0d]: got %b want 1", i-2, bus5.out_valid); end
                n_cmp++; if (bus5.out !== ex[i-2]) begin n_bad++; $display("FAIL odd_out[%0d]: got %b want %b", i-2, bus5.out, ex[i-2]); end
            end
        end
        bus5.in_valid = 1'b0;
        step();
    endtask

    task automatic test_stall();
        drive8(1'b1, 8'h80, OP_OR);  step();
        drive8(1'b1, 8'h7F, OP_AND); step();
        drive8(1'b1, 8'h01, OP_XOR); step();
        n_cmp++; if (bus8.out !== 1'b1 || bus8.out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_pre: got out=%b v=%b want out=1 v=1", bus8.out, bus8.out_valid); end
        en = 1'b0;
        drive8(1'b1, 8'hFF, OP_OR);
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (bus8.out !== 1'b1 || bus8.out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_hold[%0d]: got out=%b v=%b want out=1 v=1", i, bus8.out, bus8.out_valid); end
        end
        en = 1'b1;
        drive8(1'b0, 8'h00, OP_OR);
        step();
        n_cmp++; if (bus8.out !== 1'b0 || bus8.out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_s1: got out=%b v=%b want out=0 v=1", bus8.out, bus8.out_valid); end
        step();
        n_cmp++; if (bus8.out !== 1'b1 || bus8.out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_s2: got out=%b v=%b want out=1 v=1", bus8.out, bus8.out_valid); end
        step();
        n_cmp++; if (bus8.out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_nocapture: got v=%b want 0", bus8.out_valid); end
    endtask

    task automatic test_reset_mid();
        drive8(1'b1, 8'hFF, OP_OR); step();
        drive8(1'b1, 8'hFF, OP_OR); step();
        drive8(1'b0, 8'h00, OP_OR);
        rst_n = 1'b0;
        step();
        n_cmp++; if (bus8.out_valid !== 1'b0 || bus8.out !== 1'b0) begin n_bad++; $display("FAIL rstmid_clear: got out=%b v=%b want 0 0", bus8.out, bus8.out_valid); end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (bus8.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_stale[%0d]: got v=%b want 0", i, bus8.out_valid); end
        end
    endtask

`ifdef OR_TREE_STICKY_EN
    task automatic test_sticky();
        bus8.sticky_clr = 1'b0;
        drive8(1'b1, 8'h10, OP_OR); step();
        drive8(1'b1, 8'h00, OP_OR); step();
        step();
        n_cmp++; if (bus8.sticky !== 1'b1) begin n_bad++; $display("FAIL sticky_set: got %b want 1", bus8.sticky); end
        step(); step(); step();
        n_cmp++; if (bus8.sticky !== 1'b1) begin n_bad++; $display("FAIL sticky_hold: got %b want 1", bus8.sticky); end
        bus8.sticky_clr = 1'b1; step(); bus8.sticky_clr = 1'b0;
        n_cmp++; if (bus8.sticky !== 1'b0) begin n_bad++; $display("FAIL sticky_clr: got %b want 0", bus8.sticky); end
        drive8(1'b1, 8'h01, OP_OR); step();
        drive8(1'b0, 8'h00, OP_OR); step();
        bus8.sticky_clr = 1'b1; step(); bus8.sticky_clr = 1'b0;
        n_cmp++; if (bus8.sticky !== 1'b1 || bus8.out !== 1'b1) begin n_bad++; $display("FAIL sticky_setwins: got s=%b out=%b want 1 1", bus8.sticky, bus8.out); end
        bus8.sticky_clr = 1'b1; step(); bus8.sticky_clr = 1'b0;
        n_cmp++; if (bus8.sticky !== 1'b0) begin n_bad++; $display("FAIL sticky_clr2: got %b want 0", bus8.sticky); end
        drive8(1'b0, 8'hFF, OP_OR); step();
        drive8(1'b0, 8'h00, OP_OR);
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (bus8.sticky !== 1'b0) begin n_bad++; $display("FAIL sticky_bubble[%0d]: got %b want 0", i, bus8.sticky); end
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        drive8(1'b0, 8'h00, OP_OR);
        bus5.in_valid = 1'b0;
        bus5.a        = 5'h00;
        bus5.op       = OP_OR;
`ifdef OR_TREE_STICKY_EN
        bus8.sticky_clr = 1'b0;
        bus5.sticky_clr = 1'b0;
`endif
        #2;
        test_reset();
        test_sweep();
        test_mixed();
        test_odd_width();
        test_stall();
        test_reset_mid();
`ifdef OR_TREE_STICKY_EN
        test_sticky();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/or_tree_pipe.md
# or_tree_pipe

Parametrised, pipelined N-input reduction unit generalising the fixed 8-way OR gate to any width and four reduction modes: OR, AND, XOR and NOR. It uses one register stage per binary-tree level, with a valid bit travelling alongside the data and a global clock-enable stall. It sits in the chip-01 logic library and feeds the ALU zero-flag path and the bus-activity detectors.

## Interface
Parameters:
- WIDTH, 16, number of input bits; any value ≥ 1.
- LEVELS, derived as max(1, ceil(log2(WIDTH))), pipeline depth in cycles. Not to be overridden.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- en  in  1  pipeline advance enable; when 0, every stage holds.
- in_valid  in  1  a sample is presented on a and op this cycle.
- a  in  WIDTH  operand bits.
- op  in  2  mode: 00 OR, 01 AND, 10 XOR, 11 NOR.
- out_valid  out  1  out carries a result this cycle.
- out  out  1  reduction result.
- sticky  out  1  present only with OR_TREE_STICKY_EN (see Configuration).
- sticky_clr  in  1  present only with OR_TREE_STICKY_EN.

## Operation
- Pad a to 2^LEVELS bits with the op identity: 0 for OR, XOR and NOR; 1 for AND.
- Stage k (1..LEVELS) combines adjacent pairs of stage k−1 using the tree operator: OR for modes 00 and 11, AND for 01, XOR for 10. Each stage registers 2^(LEVELS−k) bits.
- op and valid are registered at every stage alongside the data, so mixed-mode back-to-back samples are legal.
- Final stage: out = root bit, inverted when the carried op = 11.
- WIDTH = 1: a single register stage; out = a[0], inverted for op 11.
- in_valid = 0 samples propagate as bubbles (valid = 0). Data in bubble slots is don't-care but must not reach sticky.
- No backpressure: the consumer must accept whenever out_valid = 1 and en = 1.

## Timing
- Latency: exactly LEVELS cycles with en held 1. A sample accepted at edge t appears with out_valid = 1 after edge t+LEVELS−1, i.e. visible for the cycle following that edge.
- Throughput: one sample per enabled cycle.
- en = 0: all data, op and valid registers hold; out and out_valid remain stable. A sample presented while en = 0 is not captured.
- Reset: when rst_n = 0 at an edge, all valid bits, out, out_valid and sticky clear to 0. Data registers also clear.
- Reset has priority over en. Samples in flight when reset arrives are discarded, and no out_valid pulse follows reset.

## Configuration
- OR_TREE_STICKY_EN defined: adds sticky and sticky_clr.
  - On each enabled edge, sticky ← (sticky & ~sticky_clr) | (out_valid_next & out_next), where out_next is the final-stage value being registered.
  - Simultaneous clear and set: set wins.
  - sticky_clr is ignored while en = 0.
- Not defined: neither port exists and no sticky state is built.

## Structure
- Package or_tree_pkg:
  - op encodings OP_OR, OP_AND, OP_XOR, OP_NOR.
  - function clog2_min1 to compute LEVELS.
  - function op_identity(op).
- One sub-module, or_tree_stage, parametrised by input width.
  - Performs the pairwise combine and registers data, op and valid, with en and rst_n handling.
  - Instantiated LEVELS times in a generate loop.

## Test plan
All scenarios use WIDTH = 8, LEVELS = 3.
- Single-bit sweep: op = OR, a = 0x00, 0x01, 0x00, 0x02, 0xFF on consecutive cycles → out = 0, 1, 0, 1, 1, starting 3 cycles later with out_valid = 1 each cycle.
- Mixed modes back-to-back: (0xFF, AND), (0xFE, AND), (0x07, XOR), (0x00, NOR) → 1, 0, 1, 1.
- Odd width: WIDTH = 5, a = 0x1F, op AND → 1, confirming padding is identity and not 0. Same with a = 0x10, op OR → 1.
- Stall: en dropped for 4 cycles with 3 samples in flight → out and out_valid frozen throughout. The results emerge unchanged and in order once en = 1.
- Reset mid-stream: rst_n = 0 for one edge while 2 samples are in flight → out_valid = 0 and out = 0 on the next cycle, and no stale result appears afterwards.
- STICKY_EN build:
  - Single OR result of 1, then zeros → sticky stays 1.
  - sticky_clr pulse → sticky drops to 0.
  - Clear coinciding with a new result of 1 → sticky stays 1.
  - A bubble carrying data 0xFF → sticky does not set.
